uart_avm_arbiter: RTL
=====================

# uart_avm_arbiter

Round-robin arbiter that shares the single UART Avalon-MM master port between N internal requesters: the external bridge, the receiver DMA and the transmitter DMA. It sits between the requester-side master buses and the top-level m1 master. It forwards one granted command at a time and holds waitrequest on the losers. Pipelined read responses are steered back to the issuing requester through an in-order ID FIFO.

## Interface
- N_REQ, 3, number of requesters (2..8)
- ADDR_W, 16, address width
- DATA_W, 32, data width
- MAX_OUT, 4, max outstanding reads (power of two, ≥2)

- csi_clk  in  1  clock
- rsi_reset_n  in  1  asynchronous active-low reset
- req_write  in  N_REQ  per-requester write strobe
- req_read  in  N_REQ  per-requester read strobe
- req_address  in  N_REQ*ADDR_W  packed addresses, requester i at slice i
- req_writedata  in  N_REQ*DATA_W  packed write data
- req_waitrequest  out  N_REQ  per-requester stall
- req_readdatavalid  out  N_REQ  per-requester response strobe
- req_readdata  out  DATA_W  shared response data, valid only with own readdatavalid
- avm_m1_write / avm_m1_read  out  1  downstream command strobes
- avm_m1_address  out  ADDR_W  downstream address
- avm_m1_writedata  out  DATA_W  downstream write data
- avm_m1_waitrequest  in  1  downstream stall
- avm_m1_readdatavalid  in  1  downstream response strobe
- avm_m1_readdata  in  DATA_W  downstream response data
- rsp_orphan  out  1  sticky flag: response arrived with empty ID FIFO

## Operation
- States: IDLE, GRANT. Grant register g (index), last-served pointer p.
- IDLE: if any requester i has read|write pending, register g = first pending index scanning p+1, p+2, … wrapping modulo N_REQ, and go to GRANT. Otherwise stay.
- GRANT: m1 command = requester g's signals. req_waitrequest[g] = avm_m1_waitrequest. All others = 1.
- Acceptance = (m1_write|m1_read) & !avm_m1_waitrequest. On acceptance: p ← g, then re-arbitrate in the same edge (next pending after g → GRANT with new g, none → IDLE). One transfer per grant.
- Read gating: when the ID FIFO count == MAX_OUT, a granted read is held. m1_read = 0 and req_waitrequest[g] = 1. A granted write is never gated.
- Read and write asserted together by one requester: write is forwarded, read is ignored for that transfer.
- Granted requester drops both strobes before acceptance: return to IDLE next edge, p unchanged.
- Read acceptance pushes g into the ID FIFO. avm_m1_readdatavalid pops the FIFO head h and asserts req_readdatavalid[h] combinationally. Same-cycle push and pop is allowed.
- avm_m1_readdatavalid with an empty FIFO: response dropped, rsp_orphan set until reset.
- req_readdata = avm_m1_readdata, unregistered.

## Timing
- Reset values: state IDLE, p = N_REQ-1, FIFO empty, avm_m1_write/read 0, address/writedata 0, req_waitrequest all 1, req_readdatavalid 0, rsp_orphan 0.
- Outside GRANT, every req_waitrequest bit is 1 and the m1 strobes are 0.
- Request at edge t from IDLE: command on m1 in cycle t+1. With zero waitrequest it is accepted in t+1.
- Back-to-back traffic from different requesters: one command per cycle, with no idle bubble.
- Response latency through the arbiter: 0 cycles.
- FIFO count is registered. Read gating uses the count at the start of the cycle, so a same-cycle pop does not unblock.
- Reset mid-operation clears the FIFO and grant. Late responses then set rsp_orphan.

## Configuration
- UART_ARB_FIXED_PRIO_EN defined: the IDLE and re-arbitration scan always starts at index 0, giving fixed priority with 0 highest. p is unused.
- Undefined: round-robin as above.

## Structure
- Package uart_arb_pkg: state enum (IDLE, GRANT) and a clog2-based index width function.
- Sub-module uart_arb_id_fifo: MAX_OUT-deep FIFO of index values with push, pop, head, count, full and empty.

## Test plan
- Requesters 0, 1 and 2 all assert read continuously with zero waitrequest -> m1 grant order 0,1,2,0,1,2 in consecutive cycles. Responses with readdata 0xA0,0xA1,0xA2 reach requesters 0,1,2 respectively.
- Requester 1 write to 0x0010 with m1 waitrequest held high for 3 cycles -> m1 command stable for 4 cycles. req_waitrequest[1] mirrors m1 and others stay 1. Accepted in cycle 4.
- MAX_OUT=4, 5 reads with no responses -> 5th read is held (m1_read=0). After 1 readdatavalid it issues the next cycle after the count update.
- avm_m1_readdatavalid with nothing outstanding -> no req_readdatavalid asserted, rsp_orphan=1 and sticky.
- rsi_reset_n pulsed low with 2 reads outstanding -> all outputs return to reset values. Subsequent 2 responses set rsp_orphan.
- With UART_ARB_FIXED_PRIO_EN, requesters 0 and 2 both pending continuously -> requester 2 never granted while 0 requests.

Source files
------------

// File: rtl/uart_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_arb_pkg
// Purpose  : Shared types and helpers for the UART Avalon-MM master arbiter.
//            Provides the arbiter state enum and an index-width function.
// Revision : 1.0  initial release
// ============================================================================
package uart_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Bits needed to hold an index in 0..n-1; never less than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_arb_id_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_arb_id_fifo
// Purpose  : In-order FIFO of requester indices for outstanding reads.
//            Push and pop in the same cycle are allowed; push while full and
//            pop while empty are ignored.
// Ports    : clk, rst_n (async active-low)
//            push, push_data       - enqueue an index
//            pop                   - dequeue the head
//            head                  - oldest index (valid when !empty)
//            count, full, empty    - registered occupancy
// Revision : 1.0  initial release
// ============================================================================
module uart_arb_id_fifo
  import uart_arb_pkg::*;
#(
  parameter int DEPTH = 4,   // power of two, >= 2
  parameter int WIDTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic [idx_w(DEPTH):0]  count,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = idx_w(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_count == (PTR_W+1)'(DEPTH));
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign head   = r_mem[r_rd_ptr];
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/uart_avm_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_avm_arbiter
// Purpose  : Shares the single UART Avalon-MM master (m1) between N_REQ
//            requesters. One granted command is forwarded at a time; losers
//            see waitrequest. Read responses are steered back in order via
//            an ID FIFO. Compile option UART_ARB_FIXED_PRIO_EN selects fixed
//            priority (index 0 highest) instead of round-robin.
// Ports    : csi_clk, rsi_reset_n (async active-low)
//            req_*        - packed per-requester command/response buses
//            avm_m1_*     - downstream Avalon-MM master
//            rsp_orphan   - sticky: response seen with nothing outstanding
// Revision : 1.0  initial release
// ============================================================================
module uart_avm_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ   = 3,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int MAX_OUT = 4
) (
  input  logic                      csi_clk,
  input  logic                      rsi_reset_n,
  input  logic [N_REQ-1:0]          req_write,
  input  logic [N_REQ-1:0]          req_read,
  input  logic [N_REQ*ADDR_W-1:0]   req_address,
  input  logic [N_REQ*DATA_W-1:0]   req_writedata,
  output logic [N_REQ-1:0]          req_waitrequest,
  output logic [N_REQ-1:0]          req_readdatavalid,
  output logic [DATA_W-1:0]         req_readdata,
  output logic                      avm_m1_write,
  output logic                      avm_m1_read,
  output logic [ADDR_W-1:0]         avm_m1_address,
  output logic [DATA_W-1:0]         avm_m1_writedata,
  input  logic                      avm_m1_waitrequest,
  input  logic                      avm_m1_readdatavalid,
  input  logic [DATA_W-1:0]         avm_m1_readdata,
  output logic                      rsp_orphan
);

  localparam int IDX_W = idx_w(N_REQ);
  localparam int CNT_W = idx_w(MAX_OUT) + 1;

  arb_state_t       r_state, w_state_nxt;
  logic [IDX_W-1:0] r_grant, w_grant_nxt;
  logic [IDX_W-1:0] w_scan_base;
  logic [IDX_W-1:0] w_pick;
  logic             w_found;
  int               w_best;
  logic [N_REQ-1:0] w_pend;
  logic             w_g_write, w_g_read, w_gated, w_accept;
  logic             w_push, w_pop;
  logic [IDX_W-1:0] w_head;
  logic [CNT_W-1:0] w_count;
  logic             w_full, w_empty;
  logic             r_orphan;

  assign w_pend = req_write | req_read;

`ifdef UART_ARB_FIXED_PRIO_EN
  // Scanning "after N_REQ-1" starts at index 0: fixed priority, 0 highest.
  assign w_scan_base = IDX_W'(N_REQ - 1);
`else
  logic [IDX_W-1:0] r_ptr, w_ptr_nxt;
  // On re-arbitration p is about to become g, so scan from g directly.
  assign w_scan_base = (r_state == GRANT) ? r_grant : r_ptr;
`endif

  // Pick the pending index at the smallest circular distance after the base.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_best  = N_REQ;
    for (int j = 0; j < N_REQ; j++) begin
      if (w_pend[j] &&
          ((j + 2*N_REQ - int'(w_scan_base) - 1) % N_REQ) < w_best) begin
        w_best  = (j + 2*N_REQ - int'(w_scan_base) - 1) % N_REQ;
        w_pick  = IDX_W'(j);
        w_found = 1'b1;
      end
    end
  end

  // A simultaneous write wins; the read is ignored for that transfer.
  assign w_g_write = req_write[r_grant];
  assign w_g_read  = req_read[r_grant] & ~req_write[r_grant];
  // Gate on the registered count so a same-cycle pop cannot unblock.
  assign w_gated   = w_g_read & (w_count == CNT_W'(MAX_OUT));
  assign w_accept  = (avm_m1_write | avm_m1_read) & ~avm_m1_waitrequest;
  assign w_push    = w_accept & avm_m1_read & ~w_full;
  assign w_pop     = avm_m1_readdatavalid & ~w_empty;

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
`ifndef UART_ARB_FIXED_PRIO_EN
    w_ptr_nxt   = r_ptr;
`endif
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt = GRANT;
          w_grant_nxt = w_pick;
        end
      end
      GRANT: begin
        if (w_accept) begin
`ifndef UART_ARB_FIXED_PRIO_EN
          w_ptr_nxt = r_grant;
`endif
          if (w_found) w_grant_nxt = w_pick;
          else         w_state_nxt = IDLE;
        end else if (!w_g_write && !w_g_read) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      r_state  <= IDLE;
      r_grant  <= '0;
`ifndef UART_ARB_FIXED_PRIO_EN
      r_ptr    <= IDX_W'(N_REQ - 1);
`endif
      r_orphan <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
`ifndef UART_ARB_FIXED_PRIO_EN
      r_ptr    <= w_ptr_nxt;
`endif
      if (avm_m1_readdatavalid && w_empty) r_orphan <= 1'b1;
    end
  end

  always_comb begin
    avm_m1_write     = 1'b0;
    avm_m1_read      = 1'b0;
    avm_m1_address   = '0;
    avm_m1_writedata = '0;
    req_waitrequest  = '1;
    if (r_state == GRANT) begin
      avm_m1_write              = w_g_write;
      avm_m1_read               = w_g_read & ~w_gated;
      avm_m1_address            = req_address[r_grant*ADDR_W +: ADDR_W];
      avm_m1_writedata          = req_writedata[r_grant*DATA_W +: DATA_W];
      req_waitrequest[r_grant]  = w_gated | avm_m1_waitrequest;
    end
  end

  always_comb begin
    req_readdatavalid = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_readdatavalid[i] = w_pop & (w_head == IDX_W'(i));
    end
  end

  assign req_readdata = avm_m1_readdata;
  assign rsp_orphan   = r_orphan;

  uart_arb_id_fifo #(
    .DEPTH (MAX_OUT),
    .WIDTH (IDX_W)
  ) u_id_fifo (
    .clk       (csi_clk),
    .rst_n     (rsi_reset_n),
    .push      (w_push),
    .push_data (r_grant),
    .pop       (w_pop),
    .head      (w_head),
    .count     (w_count),
    .full      (w_full),
    .empty     (w_empty)
  );

endmodule
`default_nettype wire
